tt_um_warriorjacq9: RTL and testbench

- Tiny 4-bit accumulator-less CPU core in a TinyTapeout tile.
- Fetches one instruction byte from ui_in: opcode in [3:0], immediate or register index in [7:4].
- Operands come from an external register block through a bus-request code on uo_out[3:0], with data returned on uio_in[3:0].
- The ALU result and flags are presented on uio_out, with a one-cycle done strobe on uio_out[7].

---
 rtl/tt_um_warriorjacq9_pkg.sv | 45 ++++
 rtl/warriorjacq9_alu.sv | 41 ++++
 rtl/tt_um_warriorjacq9.sv | 146 ++++++++++++++
 tb/tb_tt_um_warriorjacq9.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/tt_um_warriorjacq9_pkg.sv
// Shared types and constants for the warriorjacq9 4-bit CPU tile:
// opcodes, bus-request codes and FSM states.
package tt_um_warriorjacq9_pkg;

    localparam int DATA_W = 4;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_ADDI = 4'h1,
        OP_SUBI = 4'h2,
        OP_ANDI = 4'h3,
        OP_ORI  = 4'h4,
        OP_XORI = 4'h5,
        OP_ADD  = 4'h9,
        OP_SUB  = 4'hA
    } opcode_e;

    localparam logic [3:0] BUS_IDLE         = 4'b0000;
    localparam logic [3:0] BUS_READ_REG     = 4'b0001;
    localparam logic [3:0] BUS_NEXT_OPERAND = 4'b0011;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_RDA,
        ST_NXT,
        ST_RDB,
        ST_EXEC,
        ST_DONE
    } state_e;

    // Anything outside the defined opcode set behaves as a NOP.
    function automatic logic is_valid_op(input logic [3:0] op);
        logic valid;
        case (op)
            OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI, OP_XORI, OP_ADD, OP_SUB: valid = 1'b1;
            default: valid = 1'b0;
        endcase
        return valid;
    endfunction

    function automatic logic is_reg_op(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/warriorjacq9_alu.sv
// Combinational 4-bit ALU; carry doubles as borrow for subtraction and is
// cleared by the logic operations.
module warriorjacq9_alu
    import tt_um_warriorjacq9_pkg::*;
(
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              carry
);

    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;

    // Bit DATA_W of the widened difference is set exactly when a < b.
    always_comb begin
        sum    = {1'b0, a} + {1'b0, b};
        diff   = {1'b0, a} - {1'b0, b};
        result = '0;
        carry  = 1'b0;
        case (op)
            OP_ADDI, OP_ADD: begin
                result = sum[DATA_W-1:0];
                carry  = sum[DATA_W];
            end
            OP_SUBI, OP_SUB: begin
                result = diff[DATA_W-1:0];
                carry  = diff[DATA_W];
            end
            OP_ANDI: result = a & b;
            OP_ORI:  result = a | b;
            OP_XORI: result = a ^ b;
            default: begin
                result = '0;
                carry  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/tt_um_warriorjacq9.sv
// TinyTapeout top: instruction FSM, operand latches and registered result,
// flag, bus-request and output-enable registers.
module tt_um_warriorjacq9
    import tt_um_warriorjacq9_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    state_e            state_q, state_d;
    logic [3:0]        op_q, op_d;
    logic [3:0]        x_q, x_d;
    logic [3:0]        y_q, y_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              carry_q, carry_d;
    logic              zero_q, zero_d;
    logic              done_q, done_d;
    logic [7:0]        uo_out_q, uo_out_d;
    logic [7:0]        uio_oe_q, uio_oe_d;

    logic [DATA_W-1:0] alu_result;
    logic              alu_carry;

    logic unused_ok;
    assign unused_ok = &{1'b0, ena, uio_in[7:4], 1'b0};

    warriorjacq9_alu u_alu (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .result (alu_result),
        .carry  (alu_carry)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        x_d      = x_q;
        y_d      = y_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        carry_d  = carry_q;
        zero_d   = zero_q;

        case (state_q)
            ST_FETCH: begin
                op_d = ui_in[3:0];
                x_d  = ui_in[7:4];
                if (is_valid_op(ui_in[3:0])) begin
                    state_d = ST_RDA;
                end
            end
            ST_RDA: begin
                a_d = uio_in[DATA_W-1:0];
                if (is_reg_op(op_q)) begin
                    state_d = ST_NXT;
                end else begin
                    b_d     = x_q;
                    state_d = ST_EXEC;
                end
            end
            ST_NXT: begin
                y_d     = ui_in[7:4];
                state_d = ST_RDB;
            end
            ST_RDB: begin
                b_d     = uio_in[DATA_W-1:0];
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                result_d = alu_result;
                carry_d  = alu_carry;
                zero_d   = (alu_result == '0);
                state_d  = ST_DONE;
            end
            ST_DONE: state_d = ST_FETCH;
            default: state_d = ST_FETCH;
        endcase

        // Done trails the DONE state by one cycle so results lead it by one cycle.
        done_d = (state_q == ST_DONE);

        // Bus outputs are decoded from the next state so they line up with it.
        uo_out_d = {4'h0, BUS_IDLE};
        uio_oe_d = 8'hFF;
        case (state_d)
            ST_RDA: begin
                uo_out_d = {x_d, BUS_READ_REG};
                uio_oe_d = 8'hF0;
            end
            ST_NXT: uo_out_d = {4'h0, BUS_NEXT_OPERAND};
            ST_RDB: begin
                uo_out_d = {y_d, BUS_READ_REG};
                uio_oe_d = 8'hF0;
            end
            default: begin
                uo_out_d = {4'h0, BUS_IDLE};
                uio_oe_d = 8'hFF;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_FETCH;
            op_q     <= 4'h0;
            x_q      <= 4'h0;
            y_q      <= 4'h0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            done_q   <= 1'b0;
            uo_out_q <= 8'h00;
            uio_oe_q <= 8'hFF;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            x_q      <= x_d;
            y_q      <= y_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            done_q   <= done_d;
            uo_out_q <= uo_out_d;
            uio_oe_q <= uio_oe_d;
        end
    end

    assign uo_out  = uo_out_q;
    assign uio_out = {done_q, 1'b0, zero_q, carry_q, result_q};
    assign uio_oe  = uio_oe_q;

endmodule

// File: tb/tb_tt_um_warriorjacq9.sv
// Directed bench for tt_um_warriorjacq9: drives instructions, answers bus
// requests and scores done-strobe results against a reference model.
module tb_tt_um_warriorjacq9;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int testsRun = 0;
    int testsFailed = 0;
    logic [5:0] expQ[$];

    tt_um_warriorjacq9 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s observed=0x%02h expected=0x%02h", tag, observed, expected);
        end
    endtask

    // Reference model: returns {zero, carry, result[3:0]}.
    function automatic logic [5:0] model(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
        logic [4:0] wide;
        logic [3:0] r;
        logic       c;
        wide = 5'd0;
        r = 4'h0;
        c = 1'b0;
        case (op)
            4'h1, 4'h9: begin
                wide = {1'b0, a} + {1'b0, b};
                r = wide[3:0];
                c = wide[4];
            end
            4'h2, 4'hA: begin
                r = a - b;
                c = (a < b);
            end
            4'h3: r = a & b;
            4'h4: r = a | b;
            4'h5: r = a ^ b;
            default: r = 4'h0;
        endcase
        return {(r == 4'h0), c, r};
    endfunction

    // Scoreboard: every done strobe must match the oldest outstanding instruction.
    always @(negedge clk) begin
        if (rst_n && uio_out[7]) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_done", uio_out, 8'h00);
            end else begin
                logic [5:0] e;
                e = expQ.pop_front();
                checkOutput("done_result", uio_out, {2'b10, e});
            end
        end
    end

    // Called at a negedge during FETCH; returns at the negedge of the done cycle.
    task automatic applyStimulus(input logic [7:0] instr, input logic [3:0] aData,
                                 input logic [3:0] yIdx, input logic [3:0] bData);
        logic       isReg;
        logic [3:0] bVal;
        logic [5:0] e;
        isReg = (instr[3:0] == 4'h9) || (instr[3:0] == 4'hA);
        bVal  = isReg ? bData : instr[7:4];
        e     = model(instr[3:0], aData, bVal);
        ui_in = instr;
        expQ.push_back(e);
        @(negedge clk);
        checkOutput("rda_bus", uo_out, {instr[7:4], 4'h1});
        checkOutput("rda_oe", uio_oe, 8'hF0);
        checkOutput("rda_done_low", {7'd0, uio_out[7]}, 8'h00);
        uio_in = {4'hC, aData};
        if (isReg) begin
            @(negedge clk);
            checkOutput("nxt_bus", uo_out, 8'h03);
            checkOutput("nxt_oe", uio_oe, 8'hFF);
            ui_in = {yIdx, 4'h0};
            @(negedge clk);
            checkOutput("rdb_bus", uo_out, {yIdx, 4'h1});
            checkOutput("rdb_oe", uio_oe, 8'hF0);
            uio_in = {4'h3, bData};
        end
        @(negedge clk);
        checkOutput("exec_bus", uo_out, 8'h00);
        checkOutput("exec_oe", uio_oe, 8'hFF);
        @(negedge clk);
        checkOutput("pre_done_result", uio_out, {2'b00, e});
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_uo_out", uo_out, 8'h00);
        checkOutput("reset_uio_out", uio_out, 8'h00);
        checkOutput("reset_uio_oe", uio_oe, 8'hFF);
        rst_n = 1'b1;

        applyStimulus(8'h21, 4'h4, 4'h0, 4'h0);
        applyStimulus(8'h31, 4'h4, 4'h0, 4'h0);
        applyStimulus(8'hF1, 4'h1, 4'h0, 4'h0);
        applyStimulus(8'h52, 4'h3, 4'h0, 4'h0);
        applyStimulus(8'h29, 4'h4, 4'h1, 4'h4);
        applyStimulus(8'hC3, 4'hA, 4'h0, 4'h0);
        applyStimulus(8'h64, 4'h9, 4'h0, 4'h0);
        applyStimulus(8'hF5, 4'hF, 4'h0, 4'h0);
        applyStimulus(8'h3A, 4'h2, 4'h5, 4'h7);
        applyStimulus(8'h09, 4'h9, 4'h3, 4'h8);

        ui_in = 8'h00;
        repeat (10) begin
            @(negedge clk);
            checkOutput("nop00_bus", uo_out, 8'h00);
            checkOutput("nop00_oe", uio_oe, 8'hFF);
            checkOutput("nop00_done", {7'd0, uio_out[7]}, 8'h00);
        end
        ui_in = 8'h7F;
        repeat (10) begin
            @(negedge clk);
            checkOutput("nop7f_bus", uo_out, 8'h00);
            checkOutput("nop7f_oe", uio_oe, 8'hFF);
            checkOutput("nop7f_done", {7'd0, uio_out[7]}, 8'h00);
        end

        ui_in = 8'h21;
        uio_in = 8'h04;
        @(negedge clk);
        checkOutput("abort_rda_bus", uo_out, 8'h21);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_uo_out", uo_out, 8'h00);
        checkOutput("abort_uio_out", uio_out, 8'h00);
        checkOutput("abort_uio_oe", uio_oe, 8'hFF);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(8'h21, 4'h4, 4'h0, 4'h0);

        ui_in = 8'h00;
        repeat (3) @(negedge clk);
        checkOutput("queue_drained", 8'(expQ.size()), 8'h00);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
